// File: rtl/add_serial_param_if.sv
// rtl/add_serial_param_if.sv - start/done control and operand/result bundle for add_serial_param
// Carry-out/overflow members exist only when ADD_SERIAL_OVF_EN is defined.
interface add_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
`ifdef ADD_SERIAL_OVF_EN
    logic             cout;
    logic             ovf;
`endif

    modport master (
        output en, sub, a, b,
        input  out, busy, done
`ifdef ADD_SERIAL_OVF_EN
        , input cout, ovf
`endif
    );

    modport slave (
        input  en, sub, a, b,
        output out, busy, done
`ifdef ADD_SERIAL_OVF_EN
        , output cout, ovf
`endif
    );
endinterface

// File: rtl/add_serial_param.sv
// rtl/add_serial_param.sv - digit-serial adder/subtractor with start/done control
// Optional carry-out and signed-overflow flags are built when ADD_SERIAL_OVF_EN is defined.
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    add_serial_param_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] out_reg;
    logic             carry;
    logic [CW-1:0]    count;
    logic             busy_reg;
    logic             done_reg;

    logic [DIGIT:0]   s;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

`ifdef ADD_SERIAL_OVF_EN
    logic a_msb;
    logic b_msb;
    logic cout_reg;
    logic ovf_reg;
`endif

    assign s = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // With a single digit the whole word is consumed in one step, so there is nothing to shift.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign out_next = s[DIGIT-1:0];
            assign a_shift  = '0;
            assign b_shift  = '0;
        end else begin : g_multi
            assign out_next = {s[DIGIT-1:0], out_reg[WIDTH-1:DIGIT]};
            assign a_shift  = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
            assign b_shift  = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            out_reg  <= '0;
            carry    <= 1'b0;
            count    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.en) begin
                        // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
                        a_reg    <= bus.a;
                        b_reg    <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub;
                        count    <= '0;
                        out_reg  <= '0;
                        busy_reg <= 1'b1;
                        state    <= ADD;
`ifdef ADD_SERIAL_OVF_EN
                        a_msb    <= bus.a[WIDTH-1];
                        b_msb    <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                        cout_reg <= 1'b0;
                        ovf_reg  <= 1'b0;
`endif
                    end
                end
                ADD: begin
                    out_reg <= out_next;
                    a_reg   <= a_shift;
                    b_reg   <= b_shift;
                    carry   <= s[DIGIT];
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        state    <= DONE;
                        done_reg <= 1'b1;
`ifdef ADD_SERIAL_OVF_EN
                        cout_reg <= s[DIGIT];
                        ovf_reg  <= (a_msb == b_msb) && (out_next[WIDTH-1] != a_msb);
`endif
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.out  = out_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
`ifdef ADD_SERIAL_OVF_EN
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_add_serial_param.sv
// tb/tb_add_serial_param.sv - directed bench for add_serial_param (W8/D1, W16/D4, W8/D8)
// Flag checks are compiled in when ADD_SERIAL_OVF_EN is defined.
module tb_add_serial_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;
    int   ndone;
    int   t_prev;

    always #5 clk = ~clk;

    add_serial_param_if #(.WIDTH(8))  b8  ();
    add_serial_param_if #(.WIDTH(16)) b16 ();
    add_serial_param_if #(.WIDTH(8))  b88 ();

    add_serial_param #(.WIDTH(8),  .DIGIT(1)) u8  (.clk(clk), .rst(rst), .bus(b8));
    add_serial_param #(.WIDTH(16), .DIGIT(4)) u16 (.clk(clk), .rst(rst), .bus(b16));
    add_serial_param #(.WIDTH(8),  .DIGIT(8)) u88 (.clk(clk), .rst(rst), .bus(b88));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts one W8/D1 operation from a negedge and returns at the negedge where done is seen.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv, output int c);
        b8.a = av; b8.b = bv; b8.sub = sv; b8.en = 1'b1;
        @(negedge clk);
        b8.en = 1'b0; b8.a = ~av; b8.b = ~bv; b8.sub = ~sv;
        c = 1;
        while (b8.done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        b8.en = 0;  b8.sub = 0;  b8.a = 0;  b8.b = 0;
        b16.en = 0; b16.sub = 0; b16.a = 0; b16.b = 0;
        b88.en = 0; b88.sub = 0; b88.a = 0; b88.b = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out8", 32'(b8.out), 32'h0);
        chk("rst_busy8", 32'(b8.busy), 32'h0);
        chk("rst_done8", 32'(b8.done), 32'h0);
        chk("rst_out16", 32'(b16.out), 32'h0);
`ifdef ADD_SERIAL_OVF_EN
        chk("rst_cout8", 32'(b8.cout), 32'h0);
        chk("rst_ovf8", 32'(b8.ovf), 32'h0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // 0x35 + 0x4A: 8 ADD cycles, done seen at the 9th negedge after start
        op8(8'h35, 8'h4A, 1'b0, cyc);
        chk("add_latency", 32'(cyc), 32'd9);
        chk("add_done", 32'(b8.done), 32'h1);
        chk("add_busy_in_done", 32'(b8.busy), 32'h1);
        chk("add_out", 32'(b8.out), 32'h7F);
        @(negedge clk);
        chk("add_done_pulse", 32'(b8.done), 32'h0);
        chk("add_busy_after", 32'(b8.busy), 32'h0);
        chk("add_out_held", 32'(b8.out), 32'h7F);

        op8(8'hFF, 8'h01, 1'b0, cyc);
        chk("wrap_out", 32'(b8.out), 32'h00);
`ifdef ADD_SERIAL_OVF_EN
        chk("wrap_cout", 32'(b8.cout), 32'h1);
        chk("wrap_ovf", 32'(b8.ovf), 32'h0);
`endif
        @(negedge clk);
        op8(8'h7F, 8'h01, 1'b0, cyc);
        chk("sovf_out", 32'(b8.out), 32'h80);
`ifdef ADD_SERIAL_OVF_EN
        chk("sovf_cout", 32'(b8.cout), 32'h0);
        chk("sovf_ovf", 32'(b8.ovf), 32'h1);
`endif
        @(negedge clk);
        op8(8'h10, 8'h20, 1'b1, cyc);
        chk("sub_borrow_out", 32'(b8.out), 32'hF0);
`ifdef ADD_SERIAL_OVF_EN
        chk("sub_borrow_cout", 32'(b8.cout), 32'h0);
        chk("sub_borrow_ovf", 32'(b8.ovf), 32'h0);
`endif
        @(negedge clk);
        op8(8'h20, 8'h10, 1'b1, cyc);
        chk("sub_out", 32'(b8.out), 32'h10);
`ifdef ADD_SERIAL_OVF_EN
        chk("sub_cout", 32'(b8.cout), 32'h1);
`endif
        @(negedge clk);

        // W16/D4: 4 ADD cycles
        b16.a = 16'h1234; b16.b = 16'h0FFF; b16.sub = 1'b0; b16.en = 1'b1;
        @(negedge clk);
        b16.en = 1'b0; b16.a = 16'hFFFF;
        cyc = 1;
        while (b16.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("w16_latency", 32'(cyc), 32'd5);
        chk("w16_out", 32'(b16.out), 32'h2233);
        @(negedge clk);

        // W8/D8: single ADD cycle
        b88.a = 8'hC8; b88.b = 8'h64; b88.sub = 1'b0; b88.en = 1'b1;
        @(negedge clk);
        b88.en = 1'b0;
        cyc = 1;
        while (b88.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("w88_latency", 32'(cyc), 32'd2);
        chk("w88_out", 32'(b88.out), 32'h2C);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation
        b8.a = 8'hAA; b8.b = 8'h11; b8.sub = 1'b0; b8.en = 1'b1;
        @(negedge clk);
        b8.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(b8.busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", 32'(b8.out), 32'h0);
        chk("arst_busy", 32'(b8.busy), 32'h0);
        chk("arst_done", 32'(b8.done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op8(8'h01, 8'h01, 1'b0, cyc);
        chk("post_rst_out", 32'(b8.out), 32'h02);
        chk("post_rst_latency", 32'(cyc), 32'd9);

        // en held high: three back-to-back operations, STEPS+2 apart
        b8.a = 8'h03; b8.b = 8'h04; b8.sub = 1'b0; b8.en = 1'b1;
        ndone = 0;
        t_prev = 0;
        for (int c = 1; c <= 60 && ndone < 3; c++) begin
            @(negedge clk);
            if (b8.done === 1'b1) begin
                if (ndone > 0) chk("held_interval", 32'(c - t_prev), 32'd10);
                t_prev = c;
                ndone++;
            end
        end
        b8.en = 1'b0;
        chk("held_ndone", 32'(ndone), 32'd3);
        chk("held_out", 32'(b8.out), 32'h07);
        @(negedge clk);
        @(negedge clk);

        // en pulsed during ADD is ignored
        b8.a = 8'h05; b8.b = 8'h06; b8.sub = 1'b0; b8.en = 1'b1;
        @(negedge clk);
        b8.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        b8.a = 8'hFF; b8.b = 8'hFF; b8.en = 1'b1;
        @(negedge clk);
        b8.en = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (b8.done === 1'b1) ndone++;
        end
        chk("ignored_en_ndone", 32'(ndone), 32'd1);
        chk("ignored_en_out", 32'(b8.out), 32'h0B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
